// File: rtl/address_unit_pkg.sv
// Shared encodings for the address unit: FSM states, bus-source select codes and vector addresses.
package address_unit_pkg;

   typedef enum logic [1:0] {
      StVecLo = 2'd0,
      StVecHi = 2'd1,
      StRun   = 2'd2
   } state_e;

   localparam logic [1:0] AselPc   = 2'd0;
   localparam logic [1:0] AselMem  = 2'd1;
   localparam logic [1:0] AselAlu  = 2'd2;
   localparam logic [1:0] AselHold = 2'd3;

   localparam logic [15:0] VecNmi = 16'hFFFA;
   localparam logic [15:0] VecRes = 16'hFFFC;
   localparam logic [15:0] VecIrq = 16'hFFFE;

endpackage

// File: rtl/pc_counter.sv
// 16-bit program counter: async clear, byte-lane loads for vector fetch, full load, increment.
// Exposes both the current PC and the value it takes on the next edge.
module pc_counter (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load_lo_i,
   input  logic        load_hi_i,
   input  logic        load_i,
   input  logic        inc_i,
   input  logic [7:0]  byte_i,
   input  logic [15:0] load_val_i,
   output logic [15:0] pc_o,
   output logic [15:0] pc_next_o
);

   logic [15:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = load_val_i;
      end else if (load_lo_i) begin
         pc_d[7:0] = byte_i;
      end else if (load_hi_i) begin
         pc_d[15:8] = byte_i;
      end else if (inc_i) begin
         pc_d = pc_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o      = pc_q;
   assign pc_next_o = pc_d;

endmodule

// File: rtl/address_unit.sv
// 6502 PC / address-bus unit: runs the reset-vector fetch, then maintains PC and bus source.
// Define ADDR_UNIT_INT_VEC_EN to add the vec_load/vec_sel interrupt vector fetch.
module address_unit
   import address_unit_pkg::*;
#(
   parameter logic [15:0] RESET_VEC = VecRes
) (
   input  logic        clk,
   input  logic        res,
   input  logic        rdy,
   input  logic        pc_enable,
   input  logic        pc_load,
   input  logic [1:0]  address_select,
   input  logic [15:0] memory_address,
   input  logic [7:0]  alu_result,
   input  logic [7:0]  data_in,
`ifdef ADDR_UNIT_INT_VEC_EN
   input  logic        vec_load,
   input  logic        vec_sel,
`endif
   output logic [15:0] address_bus,
   output logic [15:0] pc,
   output logic        busy
);

   state_e      state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic        ld_lo, ld_hi, ld_full, inc;
   logic [15:0] pc_next;
   logic        vec_req;
   logic [15:0] vec_addr;

`ifdef ADDR_UNIT_INT_VEC_EN
   assign vec_req  = vec_load;
   assign vec_addr = vec_sel ? VecIrq : VecNmi;
`else
   assign vec_req  = 1'b0;
   assign vec_addr = VecIrq;
`endif

   pc_counter u_pc_counter (
      .clk_i      (clk),
      .rst_ni     (res),
      .load_lo_i  (ld_lo),
      .load_hi_i  (ld_hi),
      .load_i     (ld_full),
      .inc_i      (inc),
      .byte_i     (data_in),
      .load_val_i (memory_address),
      .pc_o       (pc),
      .pc_next_o  (pc_next)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      ld_lo   = 1'b0;
      ld_hi   = 1'b0;
      ld_full = 1'b0;
      inc     = 1'b0;
      if (rdy) begin
         unique case (state_q)
            StVecLo: begin
               ld_lo   = 1'b1;
               addr_d  = addr_q + 16'd1;
               state_d = StVecHi;
            end
            StVecHi: begin
               ld_hi   = 1'b1;
               addr_d  = {data_in, pc[7:0]};
               state_d = StRun;
            end
            StRun: begin
               // An interrupt request drops this cycle's PC update and bus select.
               if (vec_req) begin
                  addr_d  = vec_addr;
                  state_d = StVecLo;
               end else begin
                  ld_full = pc_load;
                  inc     = pc_enable & ~pc_load;
                  unique case (address_select)
                     AselPc:   addr_d = pc_next;
                     AselMem:  addr_d = memory_address;
                     AselAlu:  addr_d = {8'h00, alu_result};
                     AselHold: addr_d = addr_q;
                     default:  addr_d = addr_q;
                  endcase
               end
            end
            default: state_d = StVecLo;
         endcase
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q <= StVecLo;
         addr_q  <= RESET_VEC;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   assign address_bus = addr_q;
   assign busy        = (state_q != StRun);

endmodule
